// File: rtl/seq_divider_16_pkg.sv
// Shared definitions for the sequential divider: default width, FSM encoding
// and the Sign/Zero/Parity flag helper (also usable by the ripple adder ALU).
package seq_divider_16_pkg;

   localparam int unsigned DIV_W = 16;
   localparam int unsigned MAX_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic sign;
      logic zero;
      logic parity;
   } flags_t;

   // Word is zero-extended to MAX_W; width selects which bit is the sign.
   // Zero extension leaves both the zero test and the parity unchanged.
   function automatic flags_t calc_flags(input logic [MAX_W-1:0] word,
                                         input int unsigned      width);
      flags_t f;
      f.sign   = word[5'(width - 1)];
      f.zero   = (word == '0);
      f.parity = ~^word;
      return f;
   endfunction

endpackage

// File: rtl/seq_divider_16_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor through a full-adder chain and keep or restore the remainder.
module seq_divider_16_div_step
   import seq_divider_16_pkg::*;
#(
   parameter int unsigned W = DIV_W
) (
   input  logic [W:0]   rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] div_i,
   output logic [W:0]   rem_o,
   output logic         q_o
);

   logic [W:0] shl_c;
   logic [W:0] sub_b_c;
   logic [W:0] diff_c;
   logic       cout_c;
   logic       unused_rem_msb_c;

   // The incoming remainder is always below the divisor, so its MSB is zero.
   assign unused_rem_msb_c = rem_i[W];
   assign shl_c            = {rem_i[W-1:0], bit_i};
   assign sub_b_c          = ~{1'b0, div_i};

   // Subtract as A + ~B + 1; carry out of the top bit means no borrow.
   always_comb begin
      logic carry;
      carry  = 1'b1;
      diff_c = '0;
      for (int i = 0; i <= int'(W); i++) begin
         diff_c[i] = shl_c[i] ^ sub_b_c[i] ^ carry;
         carry     = (shl_c[i] & sub_b_c[i]) | (carry & (shl_c[i] ^ sub_b_c[i]));
      end
      cout_c = carry;
   end

   assign q_o   = cout_c;
   assign rem_o = cout_c ? diff_c : shl_c;

endmodule

// File: rtl/seq_divider_16.sv
// Multi-cycle unsigned divider: start strobe, W restoring steps, one-cycle
// done pulse; quotient, remainder and flags hold until the next completion.
module seq_divider_16
   import seq_divider_16_pkg::*;
#(
   parameter int unsigned W = DIV_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         Sign,
   output logic         Zero,
   output logic         Parity,
   output logic         DivZero
);

   localparam int unsigned CW = $clog2(W);

   logic [1:0]    state_q,   state_d;
   logic [CW-1:0] count_q,   count_d;
   logic [W-1:0]  dvd_q,     dvd_d;
   logic [W-1:0]  dvs_q,     dvs_d;
   logic [W:0]    rem_q,     rem_d;
   logic [W-1:0]  q_q,       q_d;
   logic [W-1:0]  r_q,       r_d;
   logic          busy_q,    busy_d;
   logic          done_q,    done_d;
   logic          sign_q,    sign_d;
   logic          zero_q,    zero_d;
   logic          parity_q,  parity_d;
   logic          divzero_q, divzero_d;

   logic [W:0]    step_rem_c;
   logic          step_q_c;
   logic          load_c;
   flags_t        flags_c;

   seq_divider_16_div_step #(.W(W)) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[W-1]),
      .div_i (dvs_q),
      .rem_o (step_rem_c),
      .q_o   (step_q_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         r_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sign_q    <= 1'b0;
         zero_q    <= 1'b0;
         parity_q  <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         r_q       <= r_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sign_q    <= sign_d;
         zero_q    <= zero_d;
         parity_q  <= parity_d;
         divzero_q <= divzero_d;
      end
   end

   // The dividend register doubles as the quotient accumulator: its MSB feeds
   // the step and the new quotient bit enters at the LSB.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      q_d       = q_q;
      r_d       = r_q;
      done_d    = 1'b0;
      sign_d    = sign_q;
      zero_d    = zero_q;
      parity_d  = parity_q;
      divzero_d = divzero_q;
      load_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (B != '0) begin
                  dvd_d   = A;
                  dvs_d   = B;
                  rem_d   = '0;
                  count_d = '0;
                  state_d = ST_RUN;
               end else begin
                  q_d       = '1;
                  r_d       = A;
                  divzero_d = 1'b1;
                  load_c    = 1'b1;
                  done_d    = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            dvd_d = {dvd_q[W-2:0], step_q_c};
            rem_d = step_rem_c;
            if (count_q == CW'(W - 1)) begin
               q_d       = {dvd_q[W-2:0], step_q_c};
               r_d       = step_rem_c[W-1:0];
               divzero_d = 1'b0;
               load_c    = 1'b1;
               done_d    = 1'b1;
               count_d   = '0;
               state_d   = ST_DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      flags_c = calc_flags(MAX_W'(q_d), W);
      if (load_c) begin
         sign_d   = flags_c.sign;
         zero_d   = flags_c.zero;
         parity_d = flags_c.parity;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign Q       = q_q;
   assign R       = r_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign Sign    = sign_q;
   assign Zero    = zero_q;
   assign Parity  = parity_q;
   assign DivZero = divzero_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed bench for seq_divider_16: vector table plus hand-written sequences
// for start-while-busy, reset mid-run and back-to-back operations.
module tb_seq_divider_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Q;
   logic [15:0] R;
   logic        busy;
   logic        done;
   logic        Sign;
   logic        Zero;
   logic        Parity;
   logic        DivZero;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        s;
      logic        z;
      logic        p;
      logic        dz;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   seq_divider_16 #(.W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .Q       (Q),
      .R       (R),
      .busy    (busy),
      .done    (done),
      .Sign    (Sign),
      .Zero    (Zero),
      .Parity  (Parity),
      .DivZero (DivZero)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   // Drive start for one cycle; returns at the negedge right after the accept edge.
   task automatic do_start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts clock edges after the accept edge until done is seen (bounded).
   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      do_start(v.a, v.b);
      check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
      wait_done(tag, lat);
      check($sformatf("%s_latency", tag), 32'(lat), (v.b == 16'd0) ? 32'd0 : 32'd16);
      check($sformatf("%s_q", tag), 32'(Q), 32'(v.q));
      check($sformatf("%s_r", tag), 32'(R), 32'(v.r));
      check($sformatf("%s_flags", tag), 32'({Sign, Zero, Parity, DivZero}),
            32'({v.s, v.z, v.p, v.dz}));
      @(negedge clk);
      check($sformatf("%s_done_one_cycle", tag), 32'({busy, done}), 32'd0);
   endtask

   initial begin
      int   lat;
      int   extra_done;
      int   hold_errs;
      vec_t v;

      vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h1234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'd3,     16'hFFFF,   16'd0,      16'd3,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'hFFFF,  16'h00FF,   16'h0101,   16'd0,      1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'd1234,  16'd10,     16'd123,    16'd4,      1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{16'h8000,  16'd2,      16'h4000,   16'd0,      1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1, 1'b0, 1'b1, 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({Q, R}), 32'd0);
      check("reset_status", 32'({busy, done, Sign, Zero, Parity, DivZero}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Second start during RUN and operand changes mid-run must be ignored.
      do_start(16'd50, 16'd5);
      repeat (3) @(negedge clk);
      A     = 16'd9;
      B     = 16'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = 16'd77;
      B     = 16'd0;
      wait_done("busy_start", lat);
      check("busy_start_latency", 32'(lat + 4), 32'd16);
      check("busy_start_q", 32'(Q), 32'd10);
      check("busy_start_r", 32'(R), 32'd0);
      // start raised while in DONE is also ignored
      A     = 16'd9;
      B     = 16'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_idle", 32'({busy, done}), 32'd0);
      extra_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("busy_start_extra_done", 32'(extra_done), 32'd0);
      check("busy_start_q_hold", 32'(Q), 32'd10);

      // Reset in the middle of a run aborts it and clears the outputs.
      do_start(16'd1000, 16'd3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_outputs", 32'({Q, R}), 32'd0);
      check("midrst_status", 32'({busy, done, Sign, Zero, Parity, DivZero}), 32'd0);
      extra_done = 0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      check("midrst_no_done", 32'(extra_done), 32'd0);
      v = '{16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      run_vec(v, "after_rst");

      // Back-to-back: second start in the first IDLE cycle after done.
      do_start(16'd100, 16'd7);
      wait_done("b2b_first", lat);
      check("b2b_first_q", 32'(Q), 32'd14);
      do_start(16'hFFFF, 16'h00FF);
      check("b2b_accepted", 32'(busy), 32'd1);
      hold_errs = 0;
      lat = 0;
      while (!done && lat < 40) begin
         if (Q !== 16'd14 || R !== 16'd2) hold_errs++;
         @(negedge clk);
         lat++;
      end
      check("b2b_second_done_seen", 32'(done), 32'd1);
      check("b2b_hold", 32'(hold_errs), 32'd0);
      check("b2b_second_latency", 32'(lat), 32'd16);
      check("b2b_second_q", 32'(Q), 32'h0101);
      check("b2b_second_r", 32'(R), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
